// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit bimodal counters: zero-latency IF lookup, MEM-stage update,
// misprediction detection and saturating performance counters.
module branch_predictor #(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned ENTRIES = 64,
   parameter int unsigned TAG_W   = 10,
   parameter int unsigned CNT_W   = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [XLEN-1:0]  if_pc,
   output logic             pred_hit,
   output logic             pred_taken,
   output logic [XLEN-1:0]  pred_npc,
   input  logic             upd_valid,
   input  logic [XLEN-1:0]  upd_pc,
   input  logic             upd_is_branch,
   input  logic             upd_is_jump,
   input  logic             upd_taken,
   input  logic [XLEN-1:0]  upd_target,
   input  logic             upd_pred_taken,
   input  logic [XLEN-1:0]  upd_pred_npc,
   output logic             mispredict,
   output logic [XLEN-1:0]  correct_pc,
   output logic [CNT_W-1:0] perf_branches,
   output logic [CNT_W-1:0] perf_mispred
);

   localparam int unsigned IDX_W = $clog2(ENTRIES);

   if (ENTRIES < 4 || (1 << IDX_W) != ENTRIES || IDX_W + TAG_W + 2 > XLEN) begin : g_bad_params
      $error("branch_predictor: illegal ENTRIES/TAG_W/XLEN combination");
   end

   logic [ENTRIES-1:0] valid_q;
   logic [1:0]         ctr_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [XLEN-1:0]    target_q [ENTRIES];
   logic               jump_q   [ENTRIES];

   logic [IDX_W-1:0] l_idx;
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] l_tag;
   logic [TAG_W-1:0] u_tag;
   logic             upd_hit;
   logic             upd_active;
   logic             stale_clear;
   logic [XLEN-1:0]  actual_npc;
   logic [1:0]       ctr_nxt;
   logic             unused_pc_bits;

   // Only the index/tag fields of the PCs are decoded; the remaining bits are folded here.
   assign unused_pc_bits = ^{if_pc, upd_pc};

   // IF-stage lookup, combinational and without bypass from a same-cycle update
   assign l_idx      = if_pc[IDX_W+1:2];
   assign l_tag      = if_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign pred_hit   = valid_q[l_idx] && (tag_q[l_idx] == l_tag);
   assign pred_taken = pred_hit && (jump_q[l_idx] || ctr_q[l_idx][1]);
   assign pred_npc   = pred_taken ? target_q[l_idx] : if_pc + XLEN'(4);

   // MEM-stage resolution
   assign u_idx       = upd_pc[IDX_W+1:2];
   assign u_tag       = upd_pc[IDX_W+TAG_W+1:IDX_W+2];
   assign upd_hit     = valid_q[u_idx] && (tag_q[u_idx] == u_tag);
   assign upd_active  = upd_valid && (upd_is_branch || upd_is_jump);
   assign stale_clear = upd_valid && !upd_is_branch && !upd_is_jump && upd_pred_taken && upd_hit;
   assign actual_npc  = upd_taken ? upd_target : upd_pc + XLEN'(4);
   assign mispredict  = upd_valid && (actual_npc != upd_pred_npc);
   assign correct_pc  = actual_npc;

   // Counter for the written entry: fresh allocation, saturating step on a hit, jumps pinned high
   always_comb begin
      ctr_nxt = upd_taken ? 2'b10 : 2'b01;
      if (upd_is_jump) begin
         ctr_nxt = 2'b11;
      end else if (upd_hit) begin
         ctr_nxt = ctr_q[u_idx];
         if (upd_taken && ctr_q[u_idx] != 2'b11) begin
            ctr_nxt = ctr_q[u_idx] + 2'd1;
         end else if (!upd_taken && ctr_q[u_idx] != 2'b00) begin
            ctr_nxt = ctr_q[u_idx] - 2'd1;
         end
      end
   end

   // Reset-bearing state: valid bits, counters and performance counters
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q       <= '0;
         for (int i = 0; i < int'(ENTRIES); i++) begin
            ctr_q[i] <= 2'b01;
         end
         perf_branches <= '0;
         perf_mispred  <= '0;
      end else begin
         if (upd_active) begin
            valid_q[u_idx] <= 1'b1;
            ctr_q[u_idx]   <= ctr_nxt;
         end else if (stale_clear) begin
            valid_q[u_idx] <= 1'b0;
         end
         if (upd_active && perf_branches != '1) begin
            perf_branches <= perf_branches + CNT_W'(1);
         end
         if (mispredict && perf_mispred != '1) begin
            perf_mispred <= perf_mispred + CNT_W'(1);
         end
      end
   end

   // Payload fields are only meaningful under valid, so they carry no reset
   always_ff @(posedge clk) begin
      if (upd_active) begin
         tag_q[u_idx]    <= u_tag;
         target_q[u_idx] <= upd_target;
         jump_q[u_idx]   <= upd_is_jump;
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: training, jumps, aliasing, stale entries, reset and
// counter saturation on a narrow-counter second instance sharing the same stimulus.
module tb_branch_predictor;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] if_pc;
   logic        upd_valid, upd_is_branch, upd_is_jump, upd_taken, upd_pred_taken;
   logic [31:0] upd_pc, upd_target, upd_pred_npc;

   logic        pred_hit, pred_taken, mispredict;
   logic [31:0] pred_npc, correct_pc, perf_branches, perf_mispred;

   logic        s_pred_hit, s_pred_taken, s_mispredict;
   logic [31:0] s_pred_npc, s_correct_pc;
   logic [3:0]  s_perf_branches, s_perf_mispred;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(10), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_npc(pred_npc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
      .mispredict(mispredict), .correct_pc(correct_pc),
      .perf_branches(perf_branches), .perf_mispred(perf_mispred)
   );

   branch_predictor #(.XLEN(32), .ENTRIES(64), .TAG_W(10), .CNT_W(4)) dut_small (
      .clk(clk), .reset(reset), .if_pc(if_pc),
      .pred_hit(s_pred_hit), .pred_taken(s_pred_taken), .pred_npc(s_pred_npc),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_branch(upd_is_branch),
      .upd_is_jump(upd_is_jump), .upd_taken(upd_taken), .upd_target(upd_target),
      .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
      .mispredict(s_mispredict), .correct_pc(s_correct_pc),
      .perf_branches(s_perf_branches), .perf_mispred(s_perf_mispred)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Advance to just after the next rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      upd_valid = 1'b0; upd_pc = 32'h0; upd_is_branch = 1'b0; upd_is_jump = 1'b0;
      upd_taken = 1'b0; upd_target = 32'h0; upd_pred_taken = 1'b0; upd_pred_npc = 32'h0;
   endtask

   task automatic upd(input logic [31:0] pc, input logic br, input logic jmp, input logic tk,
                      input logic [31:0] tgt, input logic [31:0] pnpc);
      upd_valid = 1'b1; upd_pc = pc; upd_is_branch = br; upd_is_jump = jmp;
      upd_taken = tk; upd_target = tgt; upd_pred_npc = pnpc;
      upd_pred_taken = (pnpc != pc + 32'd4);
   endtask

   initial begin
      reset = 1'b1;
      if_pc = 32'h100;
      idle();
      tick(); tick();
      reset = 1'b0;
      #1;
      check("rst_hit",     32'(pred_hit),   32'd0);
      check("rst_taken",   32'(pred_taken), 32'd0);
      check("rst_npc",     pred_npc,        32'h104);
      check("rst_pbr",     perf_branches,   32'd0);
      check("rst_pmp",     perf_mispred,    32'd0);
      check("rst_s_hit",   32'(s_pred_hit), 32'd0);

      // First taken branch at 0x200 misses and allocates ctr=10
      tick();
      if_pc = 32'h200;
      upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h80, 32'h204);
      #1;
      check("b1_same_hit", 32'(pred_hit),   32'd0);
      check("b1_mp",       32'(mispredict), 32'd1);
      check("b1_cpc",      correct_pc,      32'h80);
      tick();
      idle();
      #1;
      check("b1_hit",      32'(pred_hit),   32'd1);
      check("b1_taken",    32'(pred_taken), 32'd1);
      check("b1_npc",      pred_npc,        32'h80);

      // Second taken -> ctr=11, correctly predicted
      upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h80, 32'h80);
      #1;
      check("b2_mp",       32'(mispredict), 32'd0);
      tick();
      // Not taken -> ctr=10, still predicts taken
      upd(32'h200, 1'b1, 1'b0, 1'b0, 32'h80, 32'h80);
      #1;
      check("b3_mp",       32'(mispredict), 32'd1);
      check("b3_cpc",      correct_pc,      32'h204);
      tick();
      idle();
      #1;
      check("b3_taken",    32'(pred_taken), 32'd1);
      // Not taken again -> ctr=01, predicts fall-through
      upd(32'h200, 1'b1, 1'b0, 1'b0, 32'h80, 32'h80);
      tick();
      idle();
      #1;
      check("b4_hit",      32'(pred_hit),   32'd1);
      check("b4_taken",    32'(pred_taken), 32'd0);
      check("b4_npc",      pred_npc,        32'h204);

      // JAL at 0x40 -> 0x400
      if_pc = 32'h40;
      upd(32'h40, 1'b0, 1'b1, 1'b1, 32'h400, 32'h44);
      #1;
      check("j1_mp",       32'(mispredict), 32'd1);
      check("j1_cpc",      correct_pc,      32'h400);
      tick();
      idle();
      #1;
      check("j1_hit",      32'(pred_hit),   32'd1);
      check("j1_taken",    32'(pred_taken), 32'd1);
      check("j1_npc",      pred_npc,        32'h400);
      // A not-taken branch on the jump entry: from ctr=11 it drops to 10 and stays taken
      upd(32'h40, 1'b1, 1'b0, 1'b0, 32'h400, 32'h400);
      #1;
      check("j2_cpc",      correct_pc,      32'h44);
      tick();
      idle();
      #1;
      check("j2_taken",    32'(pred_taken), 32'd1);
      check("j2_npc",      pred_npc,        32'h400);

      // Same-cycle lookup/update of 0x200 (ctr=01 -> 10)
      if_pc = 32'h200;
      upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h80, 32'h204);
      #1;
      check("sc_old_tk",   32'(pred_taken), 32'd0);
      check("sc_old_npc",  pred_npc,        32'h204);
      tick();
      idle();
      #1;
      check("sc_new_tk",   32'(pred_taken), 32'd1);
      check("sc_new_npc",  pred_npc,        32'h80);

      // Alias: 0x300 shares index 0 with 0x200 under a different tag
      upd(32'h300, 1'b1, 1'b0, 1'b1, 32'h90, 32'h304);
      tick();
      idle();
      #1;
      check("al_old_hit",  32'(pred_hit),   32'd0);
      check("al_old_npc",  pred_npc,        32'h204);
      if_pc = 32'h300;
      #1;
      check("al_new_hit",  32'(pred_hit),   32'd1);
      check("al_new_npc",  pred_npc,        32'h90);

      // Stale prediction on a non-branch invalidates the entry
      upd(32'h300, 1'b0, 1'b0, 1'b0, 32'h0, 32'h90);
      #1;
      check("st_mp",       32'(mispredict), 32'd1);
      check("st_cpc",      correct_pc,      32'h304);
      tick();
      idle();
      #1;
      check("st_hit",      32'(pred_hit),   32'd0);

      // upd_valid low: no mispredict even with mismatching fields
      upd(32'h200, 1'b1, 1'b0, 1'b1, 32'h1234, 32'h0);
      upd_valid = 1'b0;
      #1;
      check("nv_mp",       32'(mispredict), 32'd0);
      tick();
      idle();
      #1;
      // Active updates: 0x200 x4, 0x40 x2, 0x200, 0x300 = 8; mispredicts: 0x200 b1,b3,b4, j1, j2, sc, alias, stale = 8
      check("pc_br",       perf_branches,           32'd8);
      check("pc_mp",       perf_mispred,            32'd8);
      check("pc_s_mp",     32'(s_perf_mispred),     32'd8);

      // Wrap of fall-through address
      if_pc = 32'hFFFF_FFFC;
      #1;
      check("wrap_npc",    pred_npc,        32'h0);

      // Asynchronous reset in the middle of an active update
      if_pc = 32'h40;
      #1;
      check("pre_rst_hit", 32'(pred_hit),   32'd1);
      upd(32'h40, 1'b0, 1'b1, 1'b1, 32'h400, 32'h44);
      #2;
      reset = 1'b1;
      #1;
      check("mr_hit_async", 32'(pred_hit),  32'd0);
      tick();
      idle();
      tick();
      reset = 1'b0;
      tick();
      check("mr_hit",      32'(pred_hit),   32'd0);
      check("mr_npc",      pred_npc,        32'h44);
      check("mr_pbr",      perf_branches,   32'd0);
      check("mr_pmp",      perf_mispred,    32'd0);

      // 18 non-branch mispredicts: narrow counter saturates at 4'hF, wide one reaches 18
      for (int i = 0; i < 18; i++) begin
         upd(32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
         tick();
      end
      idle();
      #1;
      check("sat_s_mp",    32'(s_perf_mispred),  32'hF);
      check("sat_mp",      perf_mispred,         32'd18);
      check("sat_s_br",    32'(s_perf_branches), 32'd0);
      upd(32'h500, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      tick();
      idle();
      #1;
      check("sat_s_hold",  32'(s_perf_mispred),  32'hF);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/branch_predictor.md
Name: branch_predictor

Overview:
- Parametrised branch predictor for the 5-stage pipelined RV32I core.
- IF stage: zero-latency lookup of the fetch PC (BTB tag match plus 2-bit bimodal counter) supplies the predicted next PC.
- MEM stage: the resolved branch/JAL updates the tables and is checked for misprediction; the redirect PC feeds the flush unit.
- Holds per-entry state and saturating performance counters.

Parameters:
- XLEN, 32, datapath/PC width.
- ENTRIES, 64, table depth; power of 2, minimum 4. IDX_W = log2(ENTRIES).
- TAG_W, 10, stored tag bits; require IDX_W+TAG_W+2 <= XLEN.
- CNT_W, 32, width of the performance counters.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous active-high reset.
- if_pc, input, XLEN, fetch PC.
- pred_hit, output, 1, a valid entry exists and its tag matches if_pc.
- pred_taken, output, 1, predicted taken.
- pred_npc, output, XLEN, predicted next PC.
- upd_valid, input, 1, a resolved instruction is present in MEM this cycle.
- upd_pc, input, XLEN, PC of the resolved instruction.
- upd_is_branch, input, 1, conditional branch.
- upd_is_jump, input, 1, JAL. JALR is never installed; tie 0 for JALR.
- upd_taken, input, 1, actual outcome.
- upd_target, input, XLEN, computed target (taken or not).
- upd_pred_taken, input, 1, prediction carried down the pipe.
- upd_pred_npc, input, XLEN, predicted next PC carried down the pipe.
- mispredict, output, 1, redirect required.
- correct_pc, output, XLEN, redirect address.
- perf_branches, output, CNT_W, count of resolved branch/jump updates.
- perf_mispred, output, CNT_W, count of mispredicts.

Behaviour:
- Address split: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Per entry: valid, tag, target[XLEN], is_jump, ctr[1:0].
- Reset (async, any time, including mid-update): all valid=0, all ctr=2'b01, perf counters=0. Outputs after reset: pred_hit=0, pred_taken=0, pred_npc=if_pc+4. Target/tag contents are don't-care while valid=0.
- Lookup is combinational, 0 cycles:
  - hit = valid[idx] & tag match.
  - pred_taken = hit & (is_jump | ctr[1]).
  - pred_npc = pred_taken ? target : if_pc+4. Addition wraps modulo 2^XLEN.
- Update is active when upd_valid & (upd_is_branch | upd_is_jump). Written at the clock edge.
  - Existing entry (tag hit): ctr saturating +1 if taken / -1 if not (saturate at 11 and 00). Target, is_jump and tag are rewritten.
  - Miss: allocate and overwrite the entry (direct-mapped, no replacement policy). valid=1, new tag, target, is_jump. ctr = taken ? 2'b10 : 2'b01.
  - A jump always forces ctr=2'b11.
- Actual next PC: actual_npc = upd_taken ? upd_target : upd_pc+4.
- mispredict (combinational, same cycle as the update inputs) = upd_valid & (actual_npc != upd_pred_npc).
  - This covers wrong direction, wrong target, and prediction on a non-branch.
- correct_pc = actual_npc. Only meaningful when mispredict=1.
- Non-branch with upd_pred_taken=1 (stale/aliased entry): mispredict=1, correct_pc=upd_pc+4. If the tag matches at upd_pc, that entry's valid is cleared at the edge.
- Lookup and update to the same index in the same cycle: lookup returns pre-update contents. The new value is visible from the next cycle. No bypass.
- upd_valid=0: no state change, mispredict=0.
- perf_branches increments on every active update. perf_mispred increments when mispredict=1. Both saturate at all-ones and do not wrap.
- Flush/stall are handled externally. The caller must assert upd_valid only for non-flushed MEM instructions.

Test Plan:
- Reset then if_pc=0x100 -> pred_hit=0, pred_taken=0, pred_npc=0x104. Assert reset mid-run after training -> next cycle lookup of the trained PC gives pred_hit=0 and perf counters=0.
- Branch training, each outcome taken with target 0x80:
  - Update pc=0x200, taken -> mispredict=1 (pred_npc was 0x204), correct_pc=0x80.
  - Next cycle lookup 0x200 -> hit, ctr=10, pred_npc=0x80.
  - A second taken update -> ctr=11.
  - Two not-taken updates -> ctr=01, pred_npc=0x204.
- JAL at 0x40 target 0x400 installed -> lookup pred_taken=1 on the next cycle. A not-taken update is never applied to a jump entry (a jump update forces ctr=11).
- Alias: ENTRIES=64, train pc=0x200, then update pc=0x300 (same idx, different tag) -> entry replaced. Lookup 0x200 -> pred_hit=0.
- Stale prediction on non-branch: upd_valid=1, upd_is_branch=0, upd_is_jump=0, upd_pc=0x200, upd_pred_npc=0x80 -> mispredict=1, correct_pc=0x204. Entry invalidated next cycle.
- Same-cycle lookup/update of 0x200 -> old prediction returned that cycle, new one the next cycle.
- Counter saturation: force perf_mispred to all-ones (CNT_W=4 build), cause a mispredict -> value stays 4'hF.
